// File: rtl/display_source_scheduler.sv
// Round-robin scheduler that picks which of four sources drives a four-digit display,
// keeps each granted value on screen for DWELL cycles, and supports freezing the display.
module display_source_scheduler #(
  parameter int DWELL   = 50_000_000,
  parameter int MAX_VAL = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  input  logic        freeze,
  output logic [15:0] num,
  output logic [1:0]  src_sel,
  output logic        disp_valid,
  output logic [3:0]  ack,
  output logic        clamped
);

  localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      MAX_V    = 16'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, SHOW, HOLD} state_t;

  state_t           state;
  logic             from_show;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       g;
  logic [15:0]      data_g;
  logic             grant;

  // First requesting source after the last one shown, wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    pick  = last + 2'd1;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = last + 2'(k + 1);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] d);
    return (d > MAX_V) ? MAX_V : d;
  endfunction

  always_comb begin
    g      = pick(req, src_sel);
    data_g = data0;
    case (g)
      2'd0:    data_g = data0;
      2'd1:    data_g = data1;
      2'd2:    data_g = data2;
      default: data_g = data3;
    endcase
    // Releasing a freeze that began in IDLE acts like IDLE, so a pending request is granted at once.
    grant = !freeze && (|req) &&
            ((state == IDLE) || (state == SHOW && cnt == '0) || (state == HOLD && !from_show));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      from_show  <= 1'b0;
      cnt        <= '0;
      num        <= '0;
      src_sel    <= 2'd3;
      disp_valid <= 1'b0;
      ack        <= '0;
      clamped    <= 1'b0;
    end else begin
      ack <= '0;
      if (grant) begin
        num        <= sat(data_g);
        clamped    <= (data_g > MAX_V);
        src_sel    <= g;
        disp_valid <= 1'b1;
        cnt        <= CNT_LOAD;
        ack        <= 4'b0001 << g;
        state      <= SHOW;
      end else begin
        case (state)
          IDLE: if (freeze) begin
            state     <= HOLD;
            from_show <= 1'b0;
          end
          SHOW: begin
            if (freeze) begin
              state     <= HOLD;
              from_show <= 1'b1;
            end else if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              state <= IDLE;
            end
          end
          HOLD: if (!freeze) state <= from_show ? SHOW : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench for display_source_scheduler with DWELL=4, MAX_VAL=9999.
module tb_display_source_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] data0, data1, data2, data3;
  logic        freeze;
  logic [15:0] num;
  logic [1:0]  src_sel;
  logic        disp_valid;
  logic [3:0]  ack;
  logic        clamped;

  int n_chk  = 0;
  int n_fail = 0;

  display_source_scheduler #(.DWELL(4), .MAX_VAL(9999)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .freeze(freeze), .num(num), .src_sel(src_sel), .disp_valid(disp_valid),
    .ack(ack), .clamped(clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e_num, input logic [1:0] e_sel,
                         input logic e_dv, input logic [3:0] e_ack, input logic e_clamp);
    chk({tag, ".num"}, 32'(num), 32'(e_num));
    chk({tag, ".src_sel"}, 32'(src_sel), 32'(e_sel));
    chk({tag, ".disp_valid"}, 32'(disp_valid), 32'(e_dv));
    chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
    chk({tag, ".clamped"}, 32'(clamped), 32'(e_clamp));
  endtask

  logic [15:0] seq_val [4] = '{16'd10, 16'd20, 16'd30, 16'd40};

  initial begin
    rst = 1'b1; req = '0; freeze = 1'b0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    #2;
    chk_out("reset", 16'd0, 2'd3, 1'b0, 4'b0000, 1'b0);
    tick();
    rst = 1'b0;

    // Single request granted on the first edge after reset
    req = 4'b0001; data0 = 16'd1234;
    tick();
    chk_out("first_grant", 16'd1234, 2'd0, 1'b1, 4'b0001, 1'b0);
    tick();
    chk("first_grant_ack_drop", 32'(ack), 32'd0);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    chk_out("expire_to_idle_hold", 16'd1234, 2'd0, 1'b1, 4'b0000, 1'b0);

    // Round robin over four continuous requesters
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111; data0 = 16'd10; data1 = 16'd20; data2 = 16'd30; data3 = 16'd40;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_grant%0d.num", k), 32'(num), 32'(seq_val[k % 4]));
      chk($sformatf("rr_grant%0d.ack", k), 32'(ack), 32'(4'b0001 << (k % 4)));
      for (int j = 1; j < 4; j++) begin
        tick();
        chk($sformatf("rr_hold%0d_%0d.num", k, j), 32'(num), 32'(seq_val[k % 4]));
        chk($sformatf("rr_hold%0d_%0d.ack", k, j), 32'(ack), 32'd0);
      end
    end

    // Saturation, then an unclamped grant
    req = 4'b0100; data2 = 16'hFFFF; data0 = 16'd5;
    tick();
    chk_out("clamp_grant", 16'd9999, 2'd2, 1'b1, 4'b0100, 1'b1);
    req = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    chk_out("clamp_hold", 16'd9999, 2'd2, 1'b1, 4'b0000, 1'b1);
    tick();
    chk_out("unclamp_grant", 16'd5, 2'd0, 1'b1, 4'b0001, 1'b0);

    // Freeze for ten edges with the counter at 2
    tick();
    req = 4'b0010; freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("freeze%0d.num", i), 32'(num), 32'd5);
      chk($sformatf("freeze%0d.src_sel", i), 32'(src_sel), 32'd0);
      chk($sformatf("freeze%0d.ack", i), 32'(ack), 32'd0);
    end
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("release%0d.num", i), 32'(num), 32'd5);
      chk($sformatf("release%0d.ack", i), 32'(ack), 32'd0);
    end
    tick();
    chk_out("after_freeze_grant", 16'd20, 2'd1, 1'b1, 4'b0010, 1'b0);

    // Asynchronous reset mid-dwell
    tick();
    rst = 1'b1;
    #1;
    chk_out("async_reset", 16'd0, 2'd3, 1'b0, 4'b0000, 1'b0);
    tick();
    chk_out("reset_held", 16'd0, 2'd3, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("regrant_after_reset", 16'd20, 2'd1, 1'b1, 4'b0010, 1'b0);

    // Freeze and request rising together in IDLE
    req = 4'b0000;
    for (int i = 0; i < 4; i++) tick();
    chk_out("idle_again", 16'd20, 2'd1, 1'b1, 4'b0000, 1'b0);
    freeze = 1'b1; req = 4'b0100; data2 = 16'd30;
    tick();
    chk_out("freeze_idle0", 16'd20, 2'd1, 1'b1, 4'b0000, 1'b0);
    tick();
    chk_out("freeze_idle1", 16'd20, 2'd1, 1'b1, 4'b0000, 1'b0);
    freeze = 1'b0;
    tick();
    chk_out("release_grant", 16'd30, 2'd2, 1'b1, 4'b0100, 1'b0);
    data2 = 16'd77;
    tick();
    chk_out("data_change_ignored", 16'd30, 2'd2, 1'b1, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
